// File: rtl/mux_5in1_rr_arb.sv
// mux_5in1_rr_arb: round-robin arbiter sharing one registered 5:1 mux behind a valid/ready port
// Ports: i_clk, i_rst_n (sync, active-low), i_req[4:0], i_dat0..i_dat4, i_ready in;
//        o_valid, o_dat, o_sel, o_grant, o_ack (comb), o_timeout out.
// MUX_ARB_TIMEOUT_EN adds the stall counter and o_timeout; without it GRANT waits forever.
module mux_5in1_rr_arb #(
  parameter int WIDTH = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_req,
  input  logic [WIDTH-1:0] i_dat0,
  input  logic [WIDTH-1:0] i_dat1,
  input  logic [WIDTH-1:0] i_dat2,
  input  logic [WIDTH-1:0] i_dat3,
  input  logic [WIDTH-1:0] i_dat4,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_dat,
  output logic [2:0]       o_sel,
  output logic [4:0]       o_grant,
  output logic [4:0]       o_ack
`ifdef MUX_ARB_TIMEOUT_EN
  ,
  output logic             o_timeout
`endif
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [2:0] ptr, ptr_n, sel_n, win;
  logic [WIDTH-1:0] dat_n;
  logic [WIDTH-1:0] dat [5];
  logic found, go, hs, drop;
  function automatic logic [2:0] nxt(input logic [2:0] p, input int d);
    return 3'((int'(p) + d) % 5);
  endfunction
  assign dat = '{i_dat0, i_dat1, i_dat2, i_dat3, i_dat4};
  assign o_valid = state == GRANT;
  assign o_grant = o_valid ? 5'b1 << o_sel : 5'b0;
  assign hs = o_valid & i_ready;
  assign o_ack = o_grant & {5{hs}};
  assign go = state == IDLE && found;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] stall;
  logic revoke;
  // the edge that would bring the stall count to TIMEOUT revokes instead
  assign revoke = o_valid && !i_ready && stall == CW'(TIMEOUT - 1);
  assign drop = hs | revoke;
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      stall <= '0;
      o_timeout <= 1'b0;
    end else begin
      stall <= go ? '0 : (o_valid && !i_ready) ? stall + 1'b1 : stall;
      o_timeout <= revoke;
    end
`else
  assign drop = hs;
`endif
  // search starts just after the last winner, so it becomes lowest priority
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int d = 1; d <= 5; d++)
      if (!found && i_req[nxt(ptr, d)]) begin
        win = nxt(ptr, d);
        found = 1'b1;
      end
  end
  always_comb begin
    state_n = go ? GRANT : drop ? IDLE : state;
    ptr_n = go ? win : ptr;
    sel_n = go ? win : o_sel;
    dat_n = go ? dat[win] : o_dat;
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      state <= IDLE;
      ptr <= 3'd4;
      o_sel <= '0;
      o_dat <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      o_sel <= sel_n;
      o_dat <= dat_n;
    end
endmodule

// File: tb/tb_mux_5in1_rr_arb.sv
// tb_mux_5in1_rr_arb: directed + random bench with a queue scoreboard for mux_5in1_rr_arb
module tb_mux_5in1_rr_arb;
  localparam int TO = 16;
  logic clk = 0, rst_n = 0, ready = 1;
  logic [4:0] req = 5'h1F;
  logic [7:0] d [5];
  logic valid, tout;
  logic [7:0] dat;
  logic [2:0] sel;
  logic [4:0] grant, ack;
  int errs = 0, checks = 0;
  logic [10:0] exp_q [$];
  bit live = 0, m_busy = 0, m_to = 0;
  int m_ptr = 4, m_k = 0, m_stall = 0, best, bd, dd;
  logic [7:0] m_dat;
  always #5 clk = ~clk;
  mux_5in1_rr_arb #(.WIDTH(8), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .i_dat0(d[0]), .i_dat1(d[1]), .i_dat2(d[2]), .i_dat3(d[3]), .i_dat4(d[4]),
    .i_ready(ready), .o_valid(valid), .o_dat(dat), .o_sel(sel),
    .o_grant(grant), .o_ack(ack)
`ifdef MUX_ARB_TIMEOUT_EN
    , .o_timeout(tout)
`endif
  );
`ifndef MUX_ARB_TIMEOUT_EN
  assign tout = 1'b0;
`endif
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // reference: the pending port at the smallest circular distance past the last winner wins
  always @(posedge clk) begin
    m_to = 0;
    if (!rst_n) begin
      live = 1; m_busy = 0; m_ptr = 4; m_stall = 0;
      exp_q.delete();
    end else if (!m_busy) begin
      best = -1; bd = 6;
      for (int k = 0; k < 5; k++)
        if (req[k]) begin
          dd = (k - m_ptr + 5) % 5;
          if (dd == 0) dd = 5;
          if (dd < bd) begin bd = dd; best = k; end
        end
      if (best >= 0) begin
        m_busy = 1; m_k = best; m_ptr = best; m_dat = d[best]; m_stall = 0;
        exp_q.push_back({3'(best), m_dat});
      end
    end else if (ready) m_busy = 0;
`ifdef MUX_ARB_TIMEOUT_EN
    else if (++m_stall == TO) begin
      m_busy = 0; m_to = 1;
      void'(exp_q.pop_front());
    end
`endif
  end
  // monitor: per-cycle state vs model, scoreboard pop on every handshake
  always @(negedge clk) begin
    logic [10:0] e;
    if (live && rst_n) begin
      chk("valid", valid, m_busy);
      chk("grant", grant, m_busy ? 5'(1 << m_k) : 5'b0);
      if (m_busy) begin
        chk("hold_sel", sel, m_k);
        chk("hold_dat", dat, m_dat);
      end
      chk("timeout", tout, m_to);
      if (valid && ready) begin
        if (exp_q.size() == 0) chk("hs_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("hs_sel", sel, e[10:8]);
          chk("hs_dat", dat, e[7:0]);
          chk("hs_ack", ack, 5'b1 << e[10:8]);
        end
      end else chk("ack_idle", ack, 0);
    end
  end
  initial begin
    int n;
    foreach (d[i]) d[i] = 8'(i * 17);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0); chk("rst_grant", grant, 0);
    chk("rst_sel", sel, 0); chk("rst_dat", dat, 0);
    rst_n = 1; req = 5'b00100; d[2] = 8'hA5;
    @(posedge clk); #1;
    chk("single_valid", valid, 1); chk("single_sel", sel, 2);
    chk("single_grant", grant, 5'b00100); chk("single_dat", dat, 8'hA5);
    chk("single_ack", ack, 5'b00100);
    req = 0;
    @(posedge clk); #1;
    chk("single_after", valid, 0);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1; req = 5'h1F;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("rot_valid", valid, (i % 2) == 0);
      if (i % 2 == 0) chk("rot_sel", sel, (i / 2) % 5);
    end
    req = 5'b01000; d[3] = 8'h3C; ready = 0;
    @(posedge clk); #1;
    chk("bp_sel", sel, 3); chk("bp_dat", dat, 8'h3C);
    d[3] = 8'hFF;
    repeat (7) begin
      @(posedge clk); #1;
      chk("bp_hold", dat, 8'h3C); chk("bp_valid", valid, 1); chk("bp_noack", ack, 0);
    end
    ready = 1; #1;
    chk("bp_ack", ack, 5'b01000);
    @(posedge clk); #1;
    chk("bp_done", valid, 0);
    req = 5'b00010; ready = 0;
    @(posedge clk); #1;
    chk("mid_sel", sel, 1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("mid_valid", valid, 0); chk("mid_ack", ack, 0);
    rst_n = 1; req = 5'b00011; ready = 1;
    @(posedge clk); #1;
    chk("mid_next_valid", valid, 1); chk("mid_next_sel", sel, 0);
`ifdef MUX_ARB_TIMEOUT_EN
    ready = 0; n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(posedge clk); #1;
      if (tout) n = i;
    end
    chk("to_cycles", n, TO);
    @(posedge clk); #1;
    chk("to_pulse", tout, 0); chk("to_next_sel", sel, 1); chk("to_next_valid", valid, 1);
    ready = 1;
`endif
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      req = 5'($urandom) & 5'($urandom | $urandom);
      foreach (d[k]) d[k] = 8'($urandom);
      ready = ($urandom % 4) != 0;
      if (i % 97 == 96) rst_n = 0;
      else rst_n = 1;
    end
    rst_n = 1; req = 0; ready = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
